// File: rtl/spi_imu_slave_gen_if.sv
//------------------------------------------------------------------------------
// spi_imu_slave_gen_if -- master-driven SPI pins (select, clock, MOSI). Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface spi_imu_slave_gen_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;

  modport master (output SS_n, SCLK, MOSI);
  modport slave  (input  SS_n, SCLK, MOSI);
endinterface

`default_nettype wire

// File: rtl/spi_imu_slave_gen.sv
//------------------------------------------------------------------------------
// spi_imu_slave_gen -- SPI IMU slave model: 128x8 regs, axis snapshots, ODR INT. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_imu_slave_gen #(
  parameter int         NUM_AXES  = 6,
  parameter logic [6:0] DATA_BASE = 7'h22,
  parameter logic [7:0] WHO_AM_I  = 8'h6A,
  parameter int         ODR_DIV   = 2048,
  parameter bit         AUTO_INC  = 1'b1
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  spi_imu_slave_gen_if.slave           spi,
  output wire                          MISO,
  output wire logic                    INT,
  input  wire logic [16*NUM_AXES-1:0]  axis_data
);

  localparam int         CW       = $clog2(ODR_DIV);
  localparam int         DATA_LEN = 2 * NUM_AXES;
  localparam logic [CW:0] DIV_W   = (CW+1)'(ODR_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;
  state_t state, state_nxt;

  logic [2:0]              ss_sync, sclk_sync;
  logic [1:0]              mosi_sync;
  logic [7:0]              regs [128];
  logic [16*NUM_AXES-1:0]  snap;
  logic [CW-1:0]           odr_cnt;
  logic                    int_flag;
  logic [7:0]              tx;
  logic [6:0]              rx;
  logic [2:0]              bit_cnt;
  logic                    rw;
  logic [6:0]              addr;
  logic                    skip_fall;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, byte_done;
  logic [7:0] rx_byte;
  logic [6:0] addr_nxt;
  logic cmd_done, data_done, int_clr;
  logic [3:0] odr_code, odr_shift;
  logic setup, tc;
  logic [CW:0] period;

  assign ss_fall   = ~ss_sync[1] &  ss_sync[2];
  assign ss_rise   =  ss_sync[1] & ~ss_sync[2];
  assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];
  assign rx_byte   = {rx, mosi_sync[1]};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign addr_nxt  = AUTO_INC ? addr + 7'd1 : addr;

  assign MISO = spi.SS_n ? 1'bz : tx[7];
  assign INT  = int_flag;

  function automatic logic in_data(input logic [6:0] a);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < DATA_LEN; k++)
      if (a == DATA_BASE + 7'(k)) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [7:0] resp(input logic [6:0] a);
    logic [7:0] r;
    r = regs[a];
    for (int k = 0; k < DATA_LEN; k++)
      if (a == DATA_BASE + 7'(k)) r = snap[8*k +: 8];
    if (a == 7'h0F) r = WHO_AM_I;
    if (a == 7'h1E) r = {7'b0, int_flag};
    return r;
  endfunction

  // Output data rate: code selects ODR_DIV >> (code-1), code clamped to 1..8
  always_comb begin
    odr_code  = regs[7'h11][7:4];
    setup     = regs[7'h0D][1] && (odr_code != 4'd0);
    odr_shift = (odr_code > 4'd8) ? 4'd7 : odr_code - 4'd1;
    period    = DIV_W >> odr_shift;
    tc        = setup && ({1'b0, odr_cnt} == period - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_done  = 1'b0;
    data_done = 1'b0;
    int_clr   = 1'b0;
    case (state)
      IDLE: if (ss_fall) state_nxt = CMD;
      CMD: begin
        if (ss_rise) state_nxt = IDLE;
        else if (byte_done) begin
          state_nxt = DATA;
          cmd_done  = 1'b1;
          int_clr   = rx_byte[7] && (rx_byte[6:0] == DATA_BASE);
        end
      end
      DATA: begin
        if (ss_rise) state_nxt = IDLE;
        else data_done = byte_done;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b000;
      mosi_sync <= 2'b00;
      for (int i = 0; i < 128; i++) regs[i] <= 8'h00;
      snap      <= '0;
      odr_cnt   <= '0;
      int_flag  <= 1'b0;
      tx        <= 8'h00;
      rx        <= 7'h00;
      bit_cnt   <= 3'd0;
      rw        <= 1'b0;
      addr      <= 7'h00;
      skip_fall <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[1:0], spi.SS_n};
      sclk_sync <= {sclk_sync[1:0], spi.SCLK};
      mosi_sync <= {mosi_sync[0], spi.MOSI};

      if (!setup) odr_cnt <= '0;
      else if (tc) begin
        odr_cnt <= '0;
        snap    <= axis_data;
      end else odr_cnt <= odr_cnt + 1'b1;

      // A set on the same cycle as a clear must win
      if (tc) int_flag <= 1'b1;
      else if (int_clr) int_flag <= 1'b0;

      if (state == IDLE && ss_fall) begin
        bit_cnt   <= 3'd0;
        skip_fall <= 1'b0;
      end
      if (state != IDLE && sclk_rise) begin
        rx      <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (cmd_done) begin
        rw        <= rx_byte[7];
        addr      <= rx_byte[6:0];
        tx        <= rx_byte[7] ? resp(rx_byte[6:0]) : 8'hA5;
        skip_fall <= 1'b1;
      end
      if (data_done) begin
        if (!rw && !in_data(addr) && addr != 7'h0F && addr != 7'h1E)
          regs[addr] <= rx_byte;
        if (rw) tx <= resp(addr_nxt);
        skip_fall <= rw;
        addr      <= addr_nxt;
      end
      // The fall right after a load leaves the fresh MSB on MISO for the next rise
      if (state == DATA && sclk_fall) begin
        if (skip_fall) skip_fall <= 1'b0;
        else           tx <= {tx[6:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_imu_slave_gen.sv
//------------------------------------------------------------------------------
// tb_spi_imu_slave_gen -- randomized self-checking bench against a register-level model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_imu_slave_gen;
  localparam int         NA   = 6;
  localparam logic [6:0] DB   = 7'h22;
  localparam int         DIV  = 2048;
  localparam int         HALF = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic [16*NA-1:0] axis_data;
  wire  MISO;
  wire  INT;
  spi_imu_slave_gen_if bus();

  spi_imu_slave_gen #(.NUM_AXES(NA), .DATA_BASE(DB), .WHO_AM_I(8'h6A),
                      .ODR_DIV(DIV), .AUTO_INC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .spi(bus.slave), .MISO(MISO),
    .INT(INT), .axis_data(axis_data));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_rise = 0;
  logic [7:0]  mo [16];
  logic [7:0]  mi [16];
  logic [7:0]  m_regs [128];
  logic [15:0] m_snap [NA];

  function automatic logic m_ro(input logic [6:0] a);
    int off;
    off = int'(a) - int'(DB);
    return (a == 7'h0F) || (a == 7'h1E) || (off >= 0 && off < 2*NA);
  endfunction

  function automatic logic [7:0] m_resp(input logic [6:0] a, input logic intv);
    int off;
    off = int'(a) - int'(DB);
    if (a == 7'h0F) return 8'h6A;
    if (a == 7'h1E) return {7'b0, intv};
    if (off >= 0 && off < 2*NA) return (off % 2 == 1) ? m_snap[off/2][15:8] : m_snap[off/2][7:0];
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
    for (int k = 0; k < NA; k++) m_snap[k] = 16'h0000;
  endtask

  task automatic take_snapshot();
    for (int k = 0; k < NA; k++) m_snap[k] = axis_data[16*k +: 16];
  endtask

  // Mode-0 master; rst_bit >= 0 pulses rst_n right after that SCLK rise and aborts
  task automatic spi_txn(input int nbits, input int rst_bit);
    @(negedge clk);
    bus.SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      bus.MOSI = mo[b/8][7 - b%8];
      repeat (HALF) @(negedge clk);
      mi[b/8][7 - b%8] = MISO;
      bus.SCLK = 1'b1;
      last_rise = cyc;
      if (b == rst_bit) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.SCLK = 1'b0;
        rst_n = 1'b1;
        break;
      end
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.SS_n = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic wr(input logic [6:0] a, input int n);
    logic [6:0] w;
    mo[0] = {1'b0, a};
    spi_txn(8*(n+1), -1);
    for (int i = 0; i < n; i++) begin
      w = a + 7'(i);
      if (!m_ro(w)) m_regs[w] = mo[i+1];
    end
  endtask

  task automatic rd(input logic [6:0] a, input int n);
    mo[0] = {1'b1, a};
    for (int i = 1; i <= n; i++) mo[i] = 8'($urandom);
    spi_txn(8*(n+1), -1);
  endtask

  task automatic wait_int(input int limit, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (INT === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if (INT !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", INT); end
    rd(7'h1E, 1);
    total++;
    if (mi[1] !== 8'h00) begin bad++; $display("FAIL reset_status: got %h want 00", mi[1]); end
    rd(7'h0F, 2);
    total++;
    if (mi[1] !== 8'h6A) begin bad++; $display("FAIL who_am_i: got %h want 6a", mi[1]); end
    total++;
    if (mi[2] !== m_resp(7'h10, 1'b0)) begin bad++; $display("FAIL who_next: got %h want %h", mi[2], m_resp(7'h10, 1'b0)); end
    rd(7'h40, 3);
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (mi[i] !== 8'h00) begin bad++; $display("FAIL reset_reg[%0d]: got %h want 00", i, mi[i]); end
    end
  endtask

  task automatic test_readonly();
    mo[1] = 8'($urandom);
    wr(7'h0F, 1);
    total++;
    if (mi[1] !== 8'hA5) begin bad++; $display("FAIL write_ack: got %h want a5", mi[1]); end
    rd(7'h0F, 1);
    total++;
    if (mi[1] !== 8'h6A) begin bad++; $display("FAIL who_after_write: got %h want 6a", mi[1]); end
  endtask

  task automatic test_burst_wrap();
    mo[1] = 8'hAA;
    mo[2] = 8'hBB;
    wr(7'h7F, 2);
    rd(7'h7F, 2);
    total++;
    if (mi[1] !== 8'hAA) begin bad++; $display("FAIL wrap_7f: got %h want aa", mi[1]); end
    total++;
    if (mi[2] !== 8'hBB) begin bad++; $display("FAIL wrap_00: got %h want bb", mi[2]); end
  endtask

  task automatic test_random_regs();
    logic [6:0] starts [6];
    int         lens   [6];
    logic [6:0] a;
    starts[0] = DB - 7'd1;          lens[0] = 3;
    starts[1] = DB + 7'(2*NA - 1);  lens[1] = 3;
    for (int j = 2; j < 6; j++) begin
      starts[j] = 7'($urandom_range(8'h40, 8'h78));
      lens[j]   = $urandom_range(1, 5);
    end
    for (int j = 0; j < 6; j++) begin
      for (int i = 1; i <= lens[j]; i++) mo[i] = 8'($urandom);
      wr(starts[j], lens[j]);
      rd(starts[j], lens[j]);
      for (int i = 0; i < lens[j]; i++) begin
        a = starts[j] + 7'(i);
        total++;
        if (mi[i+1] !== m_resp(a, 1'b0)) begin
          bad++; $display("FAIL rand_reg[%h]: got %h want %h", a, mi[i+1], m_resp(a, 1'b0));
        end
      end
    end
  endtask

  task automatic test_partial();
    mo[1] = 8'h5A;
    wr(7'h20, 1);
    mo[0] = 8'h20;
    mo[1] = 8'hC3;
    spi_txn(12, -1);
    rd(7'h20, 1);
    total++;
    if (mi[1] !== 8'h5A) begin bad++; $display("FAIL partial_write: got %h want 5a", mi[1]); end
  endtask

  task automatic test_odr();
    int t1, t2, t3, t4;
    bit ok;
    axis_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'hBEEF, 16'h1234};
    mo[1] = 8'h02;
    wr(7'h0D, 1);
    mo[1] = 8'h10;
    wr(7'h11, 1);
    total++;
    if (INT !== 1'b0) begin bad++; $display("FAIL int_early: got %b want 0", INT); end
    wait_int(DIV + 100, t1, ok);
    total++;
    if (!ok || (t1 - last_rise) < DIV || (t1 - last_rise) > DIV + 6) begin
      bad++; $display("FAIL first_int: got delay %0d (seen %b) want %0d..%0d", t1 - last_rise, ok, DIV, DIV + 6);
    end
    take_snapshot();
    rd(7'h1E, 1);
    total++;
    if (mi[1] !== 8'h01) begin bad++; $display("FAIL status_int: got %h want 01", mi[1]); end
    rd(DB, 2*NA);
    for (int i = 0; i < 2*NA; i++) begin
      total++;
      if (mi[i+1] !== m_resp(DB + 7'(i), 1'b0)) begin
        bad++; $display("FAIL burst_axis[%0d]: got %h want %h", i, mi[i+1], m_resp(DB + 7'(i), 1'b0));
      end
    end
    total++;
    if (INT !== 1'b0) begin bad++; $display("FAIL int_clear: got %b want 0", INT); end
    wait_int(DIV + 100, t2, ok);
    total++;
    if (!ok || (t2 - t1) != DIV) begin bad++; $display("FAIL int_period: got %0d (seen %b) want %0d", t2 - t1, ok, DIV); end
    // new live values must not show until the next period's snapshot
    axis_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    rd(DB, 1);
    total++;
    if (mi[1] !== m_resp(DB, 1'b0)) begin bad++; $display("FAIL snap_hold: got %h want %h", mi[1], m_resp(DB, 1'b0)); end
    wait_int(DIV + 100, t3, ok);
    total++;
    if (!ok || (t3 - t2) != DIV) begin bad++; $display("FAIL int_period2: got %0d (seen %b) want %0d", t3 - t2, ok, DIV); end
    take_snapshot();
    rd(DB, 4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mi[i+1] !== m_resp(DB + 7'(i), 1'b0)) begin
        bad++; $display("FAIL snap_new[%0d]: got %h want %h", i, mi[i+1], m_resp(DB + 7'(i), 1'b0));
      end
    end
    wait_int(DIV + 100, t4, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL int_reassert: got no INT want INT within %0d clk", DIV + 100); end
  endtask

  task automatic test_reset_mid();
    int t1, t2, tn;
    bit ok;
    total++;
    if (INT !== 1'b1) begin bad++; $display("FAIL int_before_reset: got %b want 1", INT); end
    mo[0] = 8'h40;
    for (int i = 1; i <= 3; i++) mo[i] = 8'($urandom);
    spi_txn(32, 20);
    model_reset();
    total++;
    if (INT !== 1'b0) begin bad++; $display("FAIL int_after_reset: got %b want 0", INT); end
    rd(7'h40, 3);
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (mi[i] !== 8'h00) begin bad++; $display("FAIL reg_after_reset[%0d]: got %h want 00", i, mi[i]); end
    end
    rd(7'h0D, 5);
    total++;
    if (mi[1] !== 8'h00 || mi[5] !== 8'h00) begin
      bad++; $display("FAIL cfg_after_reset: got %h/%h want 00/00", mi[1], mi[5]);
    end
    wait_int(3000, tn, ok);
    total++;
    if (ok) begin bad++; $display("FAIL int_unconfigured: got INT at %0d want none", tn); end
    mo[1] = 8'h02;
    wr(7'h0D, 1);
    mo[1] = 8'h30;
    wr(7'h11, 1);
    wait_int(DIV/4 + 100, t1, ok);
    total++;
    if (!ok || (t1 - last_rise) < DIV/4 || (t1 - last_rise) > DIV/4 + 6) begin
      bad++; $display("FAIL odr3_first: got delay %0d (seen %b) want %0d..%0d", t1 - last_rise, ok, DIV/4, DIV/4 + 6);
    end
    take_snapshot();
    rd(DB, 1);
    total++;
    if (mi[1] !== m_resp(DB, 1'b0)) begin bad++; $display("FAIL odr3_snap: got %h want %h", mi[1], m_resp(DB, 1'b0)); end
    wait_int(DIV/4 + 100, t2, ok);
    total++;
    if (!ok || (t2 - t1) != DIV/4) begin bad++; $display("FAIL odr3_period: got %0d (seen %b) want %0d", t2 - t1, ok, DIV/4); end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got still running at 90000 clk want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    bus.SS_n  = 1'b1;
    bus.SCLK  = 1'b0;
    bus.MOSI  = 1'b0;
    axis_data = '0;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_readonly();
    test_burst_wrap();
    test_random_regs();
    test_partial();
    test_odr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
